// File: rtl/retire_arbiter.sv
// Round-robin arbiter sharing the single retire/writeback port among NUM_REQ
// execution units. It registers one granted result per cycle and fans it out as retire strobes.
module retire_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int PHY_ADDR_WIDTH = 6,
   parameter int ROB_ADDR_WIDTH = 5
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic                               hold,
   input  logic [NUM_REQ-1:0]                 req_valid,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_value,
   input  logic [NUM_REQ*PHY_ADDR_WIDTH-1:0]  req_dest,
   input  logic [NUM_REQ*ROB_ADDR_WIDTH-1:0]  req_rob_addr,
   output logic                               phy_rf_wr_en,
   output logic [PHY_ADDR_WIDTH-1:0]          phy_rf_wr_addr,
   output logic [DATA_WIDTH-1:0]              phy_rf_wr_data,
   output logic                               busy_table_wr_en,
   output logic [PHY_ADDR_WIDTH-1:0]          busy_table_wr_addr,
   output logic                               busy_table_wr_data,
   output logic                               res_st_retire_en,
   output logic [ROB_ADDR_WIDTH-1:0]          res_st_retire_rob_addr,
   output logic [DATA_WIDTH-1:0]              res_st_retire_value,
   output logic                               rob_done_en,
   output logic [ROB_ADDR_WIDTH-1:0]          rob_done_addr
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]          rr_ptr_r;
   logic [PTR_W-1:0]          rr_ptr_nxt_s;
   logic [PTR_W-1:0]          grant_idx_s;
   logic                      grant_found_s;
   logic                      grant_en_s;
   logic                      out_v_r;
   logic [DATA_WIDTH-1:0]     out_value_r;
   logic [PHY_ADDR_WIDTH-1:0] out_dest_r;
   logic [ROB_ADDR_WIDTH-1:0] out_rob_r;
   logic                      out_en_s;
   logic                      dest_nz_s;

   // Rotating priority search starting at rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      logic [PTR_W-1:0] cand_s;
      int               sum_s;
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum_s  = int'(rr_ptr_r) + k;
         cand_s = (sum_s >= NUM_REQ) ? PTR_W'(sum_s - NUM_REQ) : PTR_W'(sum_s);
         if (!grant_found_s && req_valid[cand_s]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_s;
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Grant qualification, one-hot ready and pointer advance past the winner
   always_comb begin
      grant_en_s = grant_found_s & ~hold & ~flush & ~rst;
      req_ready  = '0;
      req_ready[grant_idx_s] = grant_en_s;
      if (grant_idx_s == PTR_W'(NUM_REQ - 1)) begin
         rr_ptr_nxt_s = '0;
      end else begin
         rr_ptr_nxt_s = grant_idx_s + PTR_W'(1);
      end
   end

   // Pointer and output register; payload only reloads on a grant so it holds otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r    <= '0;
         out_v_r     <= 1'b0;
         out_value_r <= '0;
         out_dest_r  <= '0;
         out_rob_r   <= '0;
      end else begin
         out_v_r <= grant_en_s;
         if (grant_en_s) begin
            rr_ptr_r    <= rr_ptr_nxt_s;
            out_value_r <= req_value[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];
            out_dest_r  <= req_dest[grant_idx_s*PHY_ADDR_WIDTH +: PHY_ADDR_WIDTH];
            out_rob_r   <= req_rob_addr[grant_idx_s*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH];
         end else begin
            rr_ptr_r <= rr_ptr_r;
         end
      end
   end

   // Flush kills the registered result in the cycle it is presented; phys reg 0 never writes
   always_comb begin
      out_en_s               = out_v_r & ~flush & ~rst;
      dest_nz_s              = |out_dest_r;
      phy_rf_wr_en           = out_en_s & dest_nz_s;
      phy_rf_wr_addr         = out_dest_r;
      phy_rf_wr_data         = out_value_r;
      busy_table_wr_en       = out_en_s & dest_nz_s;
      busy_table_wr_addr     = out_dest_r;
      busy_table_wr_data     = 1'b0;
      res_st_retire_en       = out_en_s;
      res_st_retire_rob_addr = out_rob_r;
      res_st_retire_value    = out_value_r;
      rob_done_en            = out_en_s;
      rob_done_addr          = out_rob_r;
   end

endmodule

// File: tb/tb_retire_arbiter.sv
// Directed self-checking bench for retire_arbiter: reset, single grant, round robin,
// dest-zero suppression, hold/flush and fairness/wrap.
module tb_retire_arbiter;

   logic         clk = 1'b0;
   logic         rst, flush, hold;
   logic [3:0]   req_valid, req_ready;
   logic [127:0] req_value;
   logic [23:0]  req_dest;
   logic [19:0]  req_rob_addr;
   logic         phy_rf_wr_en, busy_table_wr_en, busy_table_wr_data;
   logic         res_st_retire_en, rob_done_en;
   logic [5:0]   phy_rf_wr_addr, busy_table_wr_addr;
   logic [31:0]  phy_rf_wr_data, res_st_retire_value;
   logic [4:0]   res_st_retire_rob_addr, rob_done_addr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   retire_arbiter dut (
      .clk(clk), .rst(rst), .flush(flush), .hold(hold),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_value(req_value), .req_dest(req_dest), .req_rob_addr(req_rob_addr),
      .phy_rf_wr_en(phy_rf_wr_en), .phy_rf_wr_addr(phy_rf_wr_addr), .phy_rf_wr_data(phy_rf_wr_data),
      .busy_table_wr_en(busy_table_wr_en), .busy_table_wr_addr(busy_table_wr_addr),
      .busy_table_wr_data(busy_table_wr_data),
      .res_st_retire_en(res_st_retire_en), .res_st_retire_rob_addr(res_st_retire_rob_addr),
      .res_st_retire_value(res_st_retire_value),
      .rob_done_en(rob_done_en), .rob_done_addr(rob_done_addr)
   );

   task automatic set_unit(input int i, input logic [31:0] v, input logic [5:0] d, input logic [4:0] r);
      req_value[i*32 +: 32]  = v;
      req_dest[i*6 +: 6]     = d;
      req_rob_addr[i*5 +: 5] = r;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; hold = 1'b0;
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) set_unit(i, 32'(i + 1), 6'(i + 1), 5'(i + 1));
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_ready cyc%0d got=%b exp=0000", c, req_ready);
         end
         checks++;
         if ({phy_rf_wr_en, busy_table_wr_en, res_st_retire_en, rob_done_en} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_enables cyc%0d got=%b exp=0000",
                     c, {phy_rf_wr_en, busy_table_wr_en, res_st_retire_en, rob_done_en});
         end
      end
      checks++;
      if ({phy_rf_wr_addr, phy_rf_wr_data, rob_done_addr, busy_table_wr_data} !== 44'd0) begin
         failures++; $display("FAIL reset_data got addr=%0d data=%0d rob=%0d exp=0",
                              phy_rf_wr_addr, phy_rf_wr_data, rob_done_addr);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++; $display("FAIL reset_ptr_zero got=%b exp=0001", req_ready);
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_single();
      @(negedge clk);
      set_unit(2, 32'd15, 6'd3, 5'd1);
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++; $display("FAIL single_ready got=%b exp=0100", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      checks++;
      if (phy_rf_wr_en !== 1'b1 || phy_rf_wr_addr !== 6'd3 || phy_rf_wr_data !== 32'd15) begin
         failures++; $display("FAIL single_rf got en=%b addr=%0d data=%0d exp 1/3/15",
                              phy_rf_wr_en, phy_rf_wr_addr, phy_rf_wr_data);
      end
      checks++;
      if (busy_table_wr_en !== 1'b1 || busy_table_wr_addr !== 6'd3 || busy_table_wr_data !== 1'b0) begin
         failures++; $display("FAIL single_busy got en=%b addr=%0d data=%b exp 1/3/0",
                              busy_table_wr_en, busy_table_wr_addr, busy_table_wr_data);
      end
      checks++;
      if (res_st_retire_en !== 1'b1 || res_st_retire_rob_addr !== 5'd1 || res_st_retire_value !== 32'd15 ||
          rob_done_en !== 1'b1 || rob_done_addr !== 5'd1) begin
         failures++; $display("FAIL single_rs_rob got rs=%b tag=%0d val=%0d rob=%b addr=%0d exp 1/1/15/1/1",
                              res_st_retire_en, res_st_retire_rob_addr, res_st_retire_value,
                              rob_done_en, rob_done_addr);
      end
      @(negedge clk);
      checks++;
      if (rob_done_en !== 1'b0 || phy_rf_wr_en !== 1'b0 || phy_rf_wr_addr !== 6'd3) begin
         failures++; $display("FAIL single_one_cycle got rob_en=%b rf_en=%b addr=%0d exp 0/0/3",
                              rob_done_en, phy_rf_wr_en, phy_rf_wr_addr);
      end
   endtask

   task automatic test_round_robin();
      int exp_order[5] = '{0, 1, 2, 3, 0};
      pulse_reset();
      for (int i = 0; i < 4; i++) set_unit(i, 32'(100 + i), 6'(10 + i), 5'(20 + i));
      req_valid = 4'b1111;
      #1;
      for (int n = 0; n < 6; n++) begin
         if (n > 0) begin
            checks++;
            if (rob_done_en !== 1'b1 || rob_done_addr !== 5'(20 + exp_order[n-1]) ||
                phy_rf_wr_data !== 32'(100 + exp_order[n-1])) begin
               failures++; $display("FAIL rr_output n%0d got en=%b rob=%0d data=%0d exp rob=%0d",
                                    n, rob_done_en, rob_done_addr, phy_rf_wr_data, 20 + exp_order[n-1]);
            end
         end
         if (n < 5) begin
            checks++;
            if (req_ready !== 4'(1 << exp_order[n])) begin
               failures++; $display("FAIL rr_grant n%0d got=%b exp_unit=%0d", n, req_ready, exp_order[n]);
            end
            @(negedge clk);
         end else begin
            req_valid = 4'b0000;
         end
      end
   endtask

   task automatic test_dest_zero();
      @(negedge clk);
      set_unit(1, 32'd55, 6'd0, 5'd4);
      req_valid = 4'b0010;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++; $display("FAIL dz_ready got=%b exp=0010", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      checks++;
      if (phy_rf_wr_en !== 1'b0 || busy_table_wr_en !== 1'b0 || res_st_retire_en !== 1'b1 ||
          rob_done_en !== 1'b1 || rob_done_addr !== 5'd4) begin
         failures++; $display("FAIL dz_outputs got rf=%b busy=%b rs=%b rob=%b addr=%0d exp 0/0/1/1/4",
                              phy_rf_wr_en, busy_table_wr_en, res_st_retire_en, rob_done_en, rob_done_addr);
      end
   endtask

   task automatic test_hold_flush();
      @(negedge clk);
      set_unit(0, 32'd77, 6'd9, 5'd7);
      hold = 1'b1;
      req_valid = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000 || rob_done_en !== 1'b0) begin
            failures++; $display("FAIL hold_no_grant cyc%0d got ready=%b rob_en=%b exp 0000/0",
                                 c, req_ready, rob_done_en);
         end
         @(negedge clk);
      end
      hold = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++; $display("FAIL hold_release got=%b exp=0001", req_ready);
      end
      @(negedge clk);
      flush = 1'b1;
      #1;
      checks++;
      if ({phy_rf_wr_en, busy_table_wr_en, res_st_retire_en, rob_done_en} !== 4'b0000 ||
          req_ready !== 4'b0000) begin
         failures++; $display("FAIL flush_kill got en=%b ready=%b exp 0000/0000",
                              {phy_rf_wr_en, busy_table_wr_en, res_st_retire_en, rob_done_en}, req_ready);
      end
      hold = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
         failures++; $display("FAIL flush_over_hold got=%b exp=0000", req_ready);
      end
      @(negedge clk);
      flush = 1'b0; hold = 1'b0;
      req_valid = 4'b0000;
      #1;
      checks++;
      if (rob_done_en !== 1'b0) begin
         failures++; $display("FAIL flush_cleared got=%b exp=0", rob_done_en);
      end
   endtask

   task automatic test_fairness();
      int waited = 0;
      logic got3 = 1'b0;
      @(negedge clk);
      set_unit(3, 32'd33, 6'd13, 5'd19);
      req_valid = 4'b1001;
      #1;
      while (!got3 && waited < 4) begin
         if (req_ready[3] === 1'b1) got3 = 1'b1;
         else waited++;
         @(negedge clk);
         #1;
      end
      checks++;
      if (!got3) begin
         failures++; $display("FAIL fair_unit3 got=not_granted_after_%0d exp=granted_within_4", waited);
      end
      req_valid = 4'b0011;
      #1;
      checks++;
      if (rob_done_en !== 1'b1 || rob_done_addr !== 5'd19) begin
         failures++; $display("FAIL fair_output got en=%b rob=%0d exp 1/19", rob_done_en, rob_done_addr);
      end
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++; $display("FAIL fair_wrap got=%b exp=0001", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0000;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      req_value = '0; req_dest = '0; req_rob_addr = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_dest_zero();
      test_hold_flush();
      test_fairness();
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
